// File: rtl/shift_alu.sv
// Single-cycle execute-stage ALU: add/sub, bitwise logic and three barrel shifts.
// The result and carry/shift-out flag are registered; the only state is the output register.
module shift_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] outp,
    output logic             cout
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SRA = 3'b111
    } op_t;

    // Returns {shifted_out_bit, result}. The extra MSB catches the last bit leaving the word.
    function automatic logic [WIDTH:0] shift_left(
        input logic [WIDTH-1:0] a,
        input logic [SH_W-1:0]  sh
    );
        logic [WIDTH:0] ext;
        ext = {1'b0, a} << sh;
        return ext;
    endfunction

    // A guard bit below the LSB catches the last bit shifted out; sh=0 leaves it zero.
    function automatic logic [WIDTH:0] shift_right(
        input logic [WIDTH-1:0] a,
        input logic [SH_W-1:0]  sh,
        input logic             arith
    );
        logic signed [WIDTH:0] ext;
        logic signed [WIDTH:0] shifted;
        ext = $signed({a, 1'b0});
        if (arith) begin
            shifted = ext >>> sh;
        end else begin
            shifted = ext >> sh;
        end
        return {shifted[0], shifted[WIDTH:1]};
    endfunction

    op_t                 op_sel;
    logic [SH_W-1:0]     sh;
    logic [WIDTH:0]      res;

    assign op_sel = op_t'(op);
    assign sh     = i1[SH_W-1:0];

    always_comb begin
        res = '0;
        case (op_sel)
            OP_ADD:  res = {1'b0, i0} + {1'b0, i1};
            OP_SUB:  res = {1'b0, i0} + {1'b0, ~i1} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:  res = {1'b0, i0 & i1};
            OP_OR:   res = {1'b0, i0 | i1};
            OP_XOR:  res = {1'b0, i0 ^ i1};
            OP_SLL:  res = shift_left(i0, sh);
            OP_SRL:  res = shift_right(i0, sh, 1'b0);
            OP_SRA:  res = shift_right(i0, sh, 1'b1);
            default: res = '0;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            outp <= '0;
            cout <= 1'b0;
        end else begin
            outp <= res[WIDTH-1:0];
            cout <= res[WIDTH];
        end
    end

endmodule

// File: tb/tb_shift_alu.sv
// Directed-vector bench for shift_alu: reset, opcode sweeps, borrow/wrap, zero shift, mid-stream reset.
module tb_shift_alu;

    logic        clk;
    logic        reset;
    logic [2:0]  op;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [15:0] outp;
    logic        cout;

    int n_run;
    int n_fail;

    shift_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .i0    (i0),
        .i1    (i1),
        .outp  (outp),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got cout=%b outp=%h, expected cout=%b outp=%h",
                     tag, got[16], got[15:0], exp[16], exp[15:0]);
        end
    endtask

    // Drive one cycle of inputs, let the edge capture them, then compare just after it.
    task automatic step(input string tag, input logic r, input logic [2:0] o,
                        input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
        reset = r;
        op    = o;
        i0    = a;
        i1    = b;
        @(posedge clk);
        #1;
        check(tag, {cout, outp}, exp);
    endtask

    logic [16:0] sweep_a [8];
    logic [16:0] sweep_b [8];

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        op     = 3'b000;
        i0     = 16'h0000;
        i1     = 16'h0000;

        sweep_a = '{{1'b0, 16'hCB92}, {1'b1, 16'hCB6C}, {1'b0, 16'h0013}, {1'b0, 16'hCB7F},
                    {1'b0, 16'hCB6C}, {1'b0, 16'h5BF8}, {1'b1, 16'h196F}, {1'b1, 16'hF96F}};
        sweep_b = '{{1'b1, 16'h3B7E}, {1'b1, 16'h5B80}, {1'b0, 16'h4B7F}, {1'b0, 16'hEFFF},
                    {1'b0, 16'hA480}, {1'b1, 16'h8000}, {1'b1, 16'h0001}, {1'b1, 16'hFFFF}};

        @(negedge clk);
        step("reset_edge1", 1'b1, 3'b000, 16'hCB7F, 16'h0013, 17'h0_0000);
        step("reset_edge2", 1'b1, 3'b101, 16'hCB7F, 16'h0013, 17'h0_0000);
        step("first_after_reset", 1'b0, 3'b000, 16'hCB7F, 16'h0013, {1'b0, 16'hCB92});

        for (int k = 0; k < 8; k++) begin
            step($sformatf("sweep_a_op%0d", k), 1'b0, 3'(k), 16'hCB7F, 16'h0013, sweep_a[k]);
        end
        for (int k = 0; k < 8; k++) begin
            step($sformatf("sweep_b_op%0d", k), 1'b0, 3'(k), 16'hCB7F, 16'h6FFF, sweep_b[k]);
        end

        step("sub_borrow", 1'b0, 3'b001, 16'h0000, 16'h0001, {1'b0, 16'hFFFF});
        step("add_wrap",   1'b0, 3'b000, 16'hFFFF, 16'h0001, {1'b1, 16'h0000});
        step("sub_equal",  1'b0, 3'b001, 16'h1234, 16'h1234, {1'b1, 16'h0000});

        step("sll_sh0", 1'b0, 3'b101, 16'hCB7F, 16'hFFF0, {1'b0, 16'hCB7F});
        step("srl_sh0", 1'b0, 3'b110, 16'hCB7F, 16'hFFF0, {1'b0, 16'hCB7F});
        step("sra_sh0", 1'b0, 3'b111, 16'hCB7F, 16'hFFF0, {1'b0, 16'hCB7F});

        step("sra_pos_sh4", 1'b0, 3'b111, 16'h4B78, 16'h0004, {1'b1, 16'h04B7});
        step("sll_sh1",     1'b0, 3'b101, 16'h8001, 16'h0001, {1'b1, 16'h0002});

        // Reset lands on the ADD of a sweep; the remaining ops continue with normal latency.
        for (int k = 0; k < 8; k++) begin
            step($sformatf("midreset_op%0d", k), (k == 0), 3'(k), 16'hCB7F, 16'h0013,
                 (k == 0) ? 17'h0_0000 : sweep_a[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
